tdm_demux_1x8: RTL and testbench
================================

# tdm_demux_1x8

Time-division demultiplexer that accepts a serial sample stream and reassembles each 8-sample frame into eight parallel channels `a`–`h`. It is the receiving end of an 8:1 multiplexed link, where the sender steps its select lines `s2 s1 s0` from 0 to 7. Frame boundaries are marked by a start-of-frame flag. All eight outputs update together once a complete frame has been captured.

## Interface
- `WIDTH`, default 1: bit width of each sample and of each channel output.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `din`  in  WIDTH  serial sample.
- `din_valid`  in  1  `din` is valid this cycle.
- `sof`  in  1  start of frame; qualified by `din_valid`; marks the channel-`a` sample.
- `a`, `b`, `c`, `d`, `e`, `f`, `g`, `h`  out  WIDTH each  channel holding registers; channel index 0–7 in that order.
- `sel`  out  3  index of the next expected sample; `{s2,s1,s0}` order.
- `busy`  out  1  high while a frame is partially collected.
- `frame_valid`  out  1  one-cycle pulse when outputs `a`–`h` are updated.
- `frame_err`  out  1  one-cycle pulse when a partial frame is aborted by `sof`.

## Operation
- A "sample" is a cycle with `din_valid`=1. Cycles with `din_valid`=0 are gaps. Gaps of any length are allowed anywhere and change no state.
- Internal state: shadow registers `sh[0..6]` and a 3-bit counter `sel`.
- States:
  - IDLE (reset state; `busy`=0).
  - COLLECT (`busy`=1).
- IDLE:
  - Sample with `sof`=1: `sh[0]`←`din`, `sel`←1, go to COLLECT.
  - Sample with `sof`=0: ignored. No error is flagged and `sel` stays 0.
- COLLECT, sample with `sof`=0 and `sel`<7: `sh[sel]`←`din`, `sel`←`sel`+1.
- COLLECT, sample with `sof`=0 and `sel`=7 (frame complete):
  - `a..g`←`sh[0..6]` and `h`←`din`, all in the same edge.
  - `frame_valid`←1, `sel`←0, go to IDLE.
- COLLECT, sample with `sof`=1 (short frame):
  - `frame_err`←1; the partial frame is discarded and `a`–`h` are unchanged.
  - The new sample starts a fresh frame: `sh[0]`←`din`, `sel`←1, stay in COLLECT.
  - This applies at any `sel` from 1 to 7. `sof` takes priority over completion, so `sof` on what would be the 8th sample is an error plus a restart.
- Frame completion (`sel`=7 → 0) happens only on sample 8. There is no wrap-around.
- Writes to `sh` and to the outputs occur only on sample cycles.

## Timing
- Outputs after reset (`rst_n`=0 at a rising edge): `a`–`h`=0, `sel`=0, `busy`=0, `frame_valid`=0, `frame_err`=0. State is IDLE and `sh` is cleared.
- Reset mid-frame discards the partial frame with no `frame_err`. Reset overrides every simultaneous input.
- All outputs are registered; there are no combinational paths from input to output.
- Latency: the 8th sample is accepted at edge N. `a`–`h` show the new frame and `frame_valid`=1 during the cycle after edge N. `frame_valid` drops at edge N+1 unless another frame completes, which is impossible since a frame needs at least 8 samples.
- `frame_err` asserts in the cycle following the offending `sof` edge, for exactly one cycle.
- `frame_valid` and `frame_err` are never high together.
- Minimum frame period is 8 cycles. Back-to-back frames are supported: the `sof` sample may arrive in the cycle right after completion, while `frame_valid` is high.
- `busy` and `sel` change on the accepting edge.

## Structure
- Package `tdm_demux_pkg` holds:
  - `NUM_CH`=8 and `SEL_W`=3.
  - State enum `{ST_IDLE, ST_COLLECT}`.
- Sub-module `demux_1x8_dec`: combinational 3-to-8 one-hot write-enable decoder. Inputs are `sel` and an enable (`din_valid` gated by state); it drives the `sh` write enables. It is the structural inverse of the sender's 8:1 select tree.
- The top level holds the FSM, the counter, `sh` and the output registers.

## Test plan
- Reset, then idle: with `rst_n`=0 for 2 cycles, all outputs are 0. Then send `din_valid`=1, `sof`=0 for 5 cycles: `sel` stays 0, `busy`=0, no pulses.
- Basic frame (`WIDTH`=1): send `sof` with `din`=1, then 7 samples `0,1,1,0,0,1,0` back-to-back.
  - Cycle after the 8th sample: `a..h`=`1,0,1,1,0,0,1,0` and `frame_valid` pulses once.
- Gapped frame (`WIDTH`=4): send samples `0x1`–`0x8` with 3 idle cycles between each.
  - `sel` steps 1…7, then 0.
  - `a`=`0x1` … `h`=`0x8`, with one `frame_valid`.
- Short frame: send frame 1 complete (`a..h`=`1..8`), then 4 samples of frame 2, then `sof` with `din`=9 followed by 7 samples `10..16`.
  - `frame_err` pulses once and `a`–`h` hold `1..8` through the abort.
  - At completion `a..h`=`9..16`.
- Late `sof`: `sof` arrives on the 8th position → `frame_err`=1, `frame_valid`=0, `sel`=1 afterwards.
- Mid-frame reset and back-to-back frames:
  - Reset asserted after sample 5 → `a`–`h` return to 0 and there is no pulse.
  - Two consecutive frames with zero gap → `frame_valid` exactly 8 cycles apart.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_pkg
//   Shared constants, state encoding and a small helper for the 1x8
//   time-division demultiplexer.
//
//   NUM_CH   : number of channels carried in one frame (8).
//   SEL_W    : width of the channel select / sample counter (3).
//   LAST_CH  : index of the final channel in a frame (h).
//   state_t  : receiver state, ST_IDLE (waiting for sof) or
//              ST_COLLECT (frame partially captured).
//   sel_inc  : wrap-free increment of the select counter.
// -----------------------------------------------------------------------------
package tdm_demux_pkg;

  localparam int NUM_CH  = 8;
  localparam int SEL_W   = 3;
  localparam int LAST_CH = NUM_CH - 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Next select value; only ever called with sel < LAST_CH so it never wraps.
  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
    return s + SEL_W'(1);
  endfunction

endpackage

// File: rtl/tdm_demux_1x8_dec.sv
// -----------------------------------------------------------------------------
// demux_1x8_dec
//   Combinational 3-to-8 one-hot write-enable decoder. This is the receive-side
//   mirror of the sender's 8:1 select tree: exactly one enable is high when
//   en_i is set, chosen by sel_i.
//
//   Ports
//     sel_i  in  SEL_W   channel index to enable
//     en_i   in  1       global enable (qualified sample)
//     we_o   out NUM_CH  one-hot write enables, all zero when en_i = 0
// -----------------------------------------------------------------------------
module demux_1x8_dec
  import tdm_demux_pkg::*;
(
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] we_o
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
    assign we_o[gi] = en_i && (sel_i == SEL_W'(gi));
  end

endmodule

// File: rtl/tdm_demux_1x8.sv
// -----------------------------------------------------------------------------
// tdm_demux_1x8
//   Receives a serial TDM sample stream and reassembles each 8-sample frame
//   into eight parallel channel registers a..h. Samples 0..6 of a frame are
//   held in shadow registers; on the 8th sample all eight outputs are loaded
//   in the same edge so a..h always present one coherent frame.
//
//   Parameters
//     WIDTH        bit width of every sample / channel
//   Ports
//     clk          in   rising-edge clock
//     rst_n        in   synchronous active-low reset
//     din          in   serial sample
//     din_valid    in   din carries a sample this cycle
//     sof          in   start of frame (channel a sample), qualified by din_valid
//     a..h         out  channel holding registers (index 0..7)
//     sel          out  index of the next expected sample
//     busy         out  frame partially collected
//     frame_valid  out  one-cycle pulse when a..h are updated
//     frame_err    out  one-cycle pulse when a partial frame is aborted by sof
// -----------------------------------------------------------------------------
module tdm_demux_1x8
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [2:0]       sel,
  output logic             busy,
  output logic             frame_valid,
  output logic             frame_err
);

  state_t                  state_q;
  logic [SEL_W-1:0]        sel_q;
  logic                    busy_q;
  logic                    frame_valid_q;
  logic                    frame_err_q;
  logic [WIDTH-1:0]        sh_q  [NUM_CH-1];
  logic [WIDTH-1:0]        out_q [NUM_CH];

  logic [SEL_W-1:0]        wr_sel_d;
  logic                    wr_en_d;
  logic [NUM_CH-1:0]       we_d;
  logic                    frame_done_d;

  // A sof sample always lands in slot 0 regardless of the current count; in
  // IDLE only sof samples are accepted, everything else is ignored.
  always_comb begin
    wr_sel_d = sof ? '0 : sel_q;
    wr_en_d  = din_valid && (sof || (state_q == ST_COLLECT));
  end

  demux_1x8_dec u_dec (
    .sel_i (wr_sel_d),
    .en_i  (wr_en_d),
    .we_o  (we_d)
  );

  // The decoder output for the last channel doubles as the completion strobe:
  // it can only fire in COLLECT, at sel = 7, without sof.
  assign frame_done_d = we_d[LAST_CH];

  // Shadow registers for channels 0..6; channel 7 goes straight to h.
  for (genvar gi = 0; gi < NUM_CH - 1; gi++) begin : g_sh
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sh_q[gi] <= '0;
      end else if (we_d[gi]) begin
        sh_q[gi] <= din;
      end
    end
  end

  // Receiver FSM, select counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (din_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (sof) begin
              state_q <= ST_COLLECT;
              sel_q   <= SEL_W'(1);
              busy_q  <= 1'b1;
            end
          end
          ST_COLLECT: begin
            if (sof) begin
              // Short frame: drop it and restart; sof wins over completion.
              frame_err_q <= 1'b1;
              sel_q       <= SEL_W'(1);
            end else if (frame_done_d) begin
              for (int i = 0; i < NUM_CH - 1; i++) begin
                out_q[i] <= sh_q[i];
              end
              out_q[LAST_CH] <= din;
              frame_valid_q  <= 1'b1;
              sel_q          <= '0;
              busy_q         <= 1'b0;
              state_q        <= ST_IDLE;
            end else begin
              sel_q <= sel_inc(sel_q);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign a           = out_q[0];
  assign b           = out_q[1];
  assign c           = out_q[2];
  assign d           = out_q[3];
  assign e           = out_q[4];
  assign f           = out_q[5];
  assign g           = out_q[6];
  assign h           = out_q[7];
  assign sel         = sel_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
module tb_tdm_demux_1x8;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sof;
  logic [W-1:0] a, b, c, d, e, f, g, h;
  logic [2:0]   sel;
  logic         busy;
  logic         frame_valid;
  logic         frame_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t1     = 0;
  int t2     = 0;

  logic [63:0] outs;
  assign outs = {a, b, c, d, e, f, g, h};

  tdm_demux_1x8 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .e           (e),
    .f           (f),
    .g           (g),
    .h           (h),
    .sel         (sel),
    .busy        (busy),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Checks the status outputs in one go.
  task automatic chk_status(input string tag, input logic [2:0] e_sel, input logic e_busy,
                            input logic e_fv, input logic e_fe);
    chk({tag, ".sel"}, 64'(sel), 64'(e_sel));
    chk({tag, ".busy"}, 64'(busy), 64'(e_busy));
    chk({tag, ".fv"}, 64'(frame_valid), 64'(e_fv));
    chk({tag, ".fe"}, 64'(frame_err), 64'(e_fe));
  endtask

  // One sample through a rising edge; outputs are observed 1 time unit later.
  task automatic send(input logic s, input logic [W-1:0] v);
    din_valid = 1'b1;
    sof       = s;
    din       = v;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
    $display("sample sof=%0d din=%02h -> sel=%0d busy=%0d fv=%0d fe=%0d",
             s, v, sel, busy, frame_valid, frame_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; sof = 1'b0;

    // Reset for two cycles
    idle(2);
    chk("rst.outs", outs, 64'h0);
    chk_status("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Non-sof samples in IDLE are ignored
    for (int i = 0; i < 5; i++) begin
      send(1'b0, W'(8'hA0 + i));
      chk_status("idle_ign", 3'd0, 1'b0, 1'b0, 1'b0);
    end
    chk("idle_ign.outs", outs, 64'h0);

    // Basic frame, 1-bit values: 1,0,1,1,0,0,1,0
    send(1'b1, 8'h01);
    chk_status("basic.s0", 3'd1, 1'b1, 1'b0, 1'b0);
    send(1'b0, 8'h00); send(1'b0, 8'h01); send(1'b0, 8'h01);
    send(1'b0, 8'h00); send(1'b0, 8'h00); send(1'b0, 8'h01);
    chk_status("basic.s6", 3'd7, 1'b1, 1'b0, 1'b0);
    chk("basic.hold", outs, 64'h0);
    send(1'b0, 8'h00);
    chk("basic.outs", outs, 64'h01000101_00000100);
    chk_status("basic.done", 3'd0, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("basic.fv_drop", 64'(frame_valid), 64'd0);
    chk("basic.outs_hold", outs, 64'h01000101_00000100);

    // Gapped frame 1..8 with 3 idle cycles between samples
    for (int k = 1; k <= 8; k++) begin
      send(k == 1, W'(k));
      if (k < 8) begin
        chk("gap.sel", 64'(sel), 64'(k));
        idle(3);
        chk("gap.sel_hold", 64'(sel), 64'(k));
        chk("gap.fv", 64'(frame_valid), 64'd0);
      end
    end
    chk("gap.outs", outs, 64'h01020304_05060708);
    chk_status("gap.done", 3'd0, 1'b0, 1'b1, 1'b0);

    // Short frame: full frame 1..8, 4 samples, then sof 9 + 10..16
    idle(1);
    for (int k = 1; k <= 8; k++) send(k == 1, W'(k));
    chk("short.f1", outs, 64'h01020304_05060708);
    for (int k = 0; k < 4; k++) send(k == 0, W'(8'h20 + k));
    chk_status("short.part", 3'd4, 1'b1, 1'b0, 1'b0);
    send(1'b1, 8'h09);
    chk_status("short.abort", 3'd1, 1'b1, 1'b0, 1'b1);
    chk("short.outs_hold", outs, 64'h01020304_05060708);
    send(1'b0, 8'h0A);
    chk("short.fe_drop", 64'(frame_err), 64'd0);
    for (int k = 11; k <= 16; k++) send(1'b0, W'(k));
    chk("short.outs", outs, 64'h090A0B0C_0D0E0F10);
    chk_status("short.done", 3'd0, 1'b0, 1'b1, 1'b0);

    // Late sof on the 8th position
    for (int k = 0; k < 7; k++) send(k == 0, W'(8'h30 + k));
    chk("late.sel7", 64'(sel), 64'd7);
    send(1'b1, 8'h40);
    chk_status("late.abort", 3'd1, 1'b1, 1'b0, 1'b1);
    chk("late.outs_hold", outs, 64'h090A0B0C_0D0E0F10);
    for (int k = 1; k < 8; k++) send(1'b0, W'(8'h40 + k));
    chk("late.outs", outs, 64'h40414243_44454647);
    chk_status("late.done", 3'd0, 1'b0, 1'b1, 1'b0);

    // Mid-frame reset after sample 5, with sof sample held during reset
    for (int k = 0; k < 5; k++) send(k == 0, W'(8'h70 + k));
    chk("mrst.sel5", 64'(sel), 64'd5);
    rst_n = 1'b0; din_valid = 1'b1; sof = 1'b1; din = 8'hEE;
    idle(1);
    chk("mrst.outs", outs, 64'h0);
    chk_status("mrst", 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; din_valid = 1'b0; sof = 1'b0;
    idle(2);
    chk_status("mrst.after", 3'd0, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames with zero gap
    for (int k = 0; k < 8; k++) send(k == 0, W'(8'h50 + k));
    chk("b2b.fvA", 64'(frame_valid), 64'd1);
    chk("b2b.outsA", outs, 64'h50515253_54555657);
    t1 = cyc;
    for (int k = 0; k < 8; k++) begin
      send(k == 0, W'(8'h60 + k));
      if (k < 7) chk("b2b.fv_mid", 64'(frame_valid), 64'd0);
    end
    chk("b2b.fvB", 64'(frame_valid), 64'd1);
    chk("b2b.fe", 64'(frame_err), 64'd0);
    t2 = cyc;
    chk("b2b.period", 64'(t2 - t1), 64'd8);
    chk("b2b.outsB", outs, 64'h60616263_64656667);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
